// File: rtl/bus_pkg.sv
// Shared definitions for the bus generator/arbiter.
//   - ID_W       : width of the destination-ID field at the top of a packet
//   - state_t    : per-lane FSM states
//   - get_dest   : extracts the destination ID from a packet
//   - rr_next    : round-robin pick of the first pending agent at/after a pointer
package bus_pkg;

    localparam int ID_W      = 8;
    localparam int MAX_DRVRS = 64;
    localparam int MAX_PKT   = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // The packet is passed zero-extended; sz is the real packet width.
    function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT-1:0] pkt,
                                                 input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction

    // Scanning downwards means the last hit is the closest index at or after
    // ptr (modulo n). Returns ptr when nothing is pending.
    function automatic int rr_next(input int ptr,
                                  input logic [MAX_DRVRS-1:0] pend,
                                  input int n);
        int sel;
        int idx;
        sel = ptr;
        for (int k = MAX_DRVRS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (pend[idx]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_lane_arbiter.sv
// One bus lane: round-robin arbiter, IDLE->POP->PUSH FSM, packet register.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_pndng       : per-agent FIFO not-empty
//   i_d_pop       : per-agent FIFO head word
//   o_pop         : one-cycle dequeue strobe (combinational from state)
//   o_push        : one-cycle delivery strobe (combinational from state)
//   o_d_push      : delivered word; holds its last value on non-pushed ports
module bus_lane_arbiter
    import bus_pkg::*;
#(
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DRVRS-1:0]                 i_pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]    i_d_pop,
    output logic [DRVRS-1:0]                 o_pop,
    output logic [DRVRS-1:0]                 o_push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]    o_d_push
);

    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t                          r_state;
    state_t                          w_next_state;
    logic [GW-1:0]                   r_grant;
    logic [GW-1:0]                   r_ptr;
    logic [GW-1:0]                   w_pick;
    logic [GW-1:0]                   w_ptr_inc;
    logic [PCKG_SZ-1:0]              r_pkt;
    logic [DRVRS-1:0][PCKG_SZ-1:0]   r_dhold;
    logic [DRVRS-1:0]                w_pop;
    logic [DRVRS-1:0]                w_push;
    logic                            w_take;
    logic [ID_W-1:0]                 w_dest;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, pop/push strobes and destination decode
    always_comb begin
        w_next_state = r_state;
        w_pop        = '0;
        w_push       = '0;
        w_take       = 1'b0;
        w_pick       = GW'(rr_next(int'(r_ptr), MAX_DRVRS'(i_pndng), DRVRS));
        w_ptr_inc    = (r_grant == GW'(DRVRS - 1)) ? '0 : r_grant + GW'(1);
        w_dest       = get_dest(MAX_PKT'(r_pkt), PCKG_SZ);
        case (r_state)
            IDLE: begin
                if (|i_pndng) begin
                    w_next_state = POP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            POP: begin
                // A FIFO that went empty under us is skipped without a capture.
                if (i_pndng[r_grant]) begin
                    w_pop[r_grant] = 1'b1;
                    w_take         = 1'b1;
                    w_next_state   = PUSH;
                end else begin
                    w_next_state   = IDLE;
                end
            end
            PUSH: begin
                if (w_dest == BROADCAST) begin
                    w_push          = '1;
                    w_push[r_grant] = 1'b0;
                end else if (int'(w_dest) < DRVRS) begin
                    w_push[w_dest[GW-1:0]] = 1'b1;
                end else begin
                    w_push = '0;
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Grant, pointer, captured packet and per-port held output data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_pkt   <= '0;
            r_dhold <= '0;
        end else begin
            if (r_state == IDLE && (|i_pndng)) begin
                r_grant <= w_pick;
            end
            if (w_take) begin
                r_pkt <= i_d_pop[r_grant];
                r_ptr <= w_ptr_inc;
            end
            for (int j = 0; j < DRVRS; j++) begin
                if (w_push[j]) begin
                    r_dhold[j] <= r_pkt;
                end
            end
        end
    end

    // Pushed ports show the packet directly; others keep their last word
    always_comb begin
        for (int j = 0; j < DRVRS; j++) begin
            o_d_push[j] = w_push[j] ? r_pkt : r_dhold[j];
        end
    end

    assign o_pop  = w_pop;
    assign o_push = w_push;

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator/arbiter: one independent bus_lane_arbiter per bus.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pndng      : [bus][agent] FIFO not-empty
//   D_pop      : [bus][agent] FIFO head word
//   pop        : [bus][agent] dequeue strobe
//   push       : [bus][agent] delivery strobe
//   D_push     : [bus][agent] delivered word, qualified by push
module bus_generator_arbiter
    import bus_pkg::*;
#(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bus_lane_arbiter #(
            .DRVRS     (drvrs),
            .PCKG_SZ   (pckg_sz),
            .BROADCAST (broadcast)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_pndng  (pndng[b]),
            .i_d_pop  (D_pop[b]),
            .o_pop    (pop[b]),
            .o_push   (push[b]),
            .o_d_push (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
module tb_bus_generator_arbiter;

    logic                   clk;
    logic                   reset;
    logic [0:0][3:0]        pndng;
    logic [0:0][3:0][15:0]  d_pop;
    logic [0:0][3:0]        pop;
    logic [0:0][3:0]        push;
    logic [0:0][3:0][15:0]  d_push;

    logic [15:0] q [4][$];
    int          n_chk;
    int          n_fail;
    int          cyc;

    bus_generator_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .push   (push),
        .D_push (d_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        for (int j = 0; j < 4; j++) begin
            pndng[0][j] = (q[j].size() != 0);
            d_pop[0][j] = (q[j].size() != 0) ? q[j][0] : 16'h0000;
        end
    endtask

    // Agent FIFOs dequeue on the edge that ends a pop cycle.
    task automatic tick();
        logic [3:0] p;
        @(negedge clk);
        p = pop[0];
        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < 4; j++) begin
            if (p[j] === 1'b1 && q[j].size() != 0) begin
                void'(q[j].pop_front());
            end
        end
        refresh();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int last;
        int a;
        logic [15:0] pk;
        logic [1:0]  dst;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        reset  = 1'b1;
        for (int j = 0; j < 4; j++) q[j].push_back(16'h0100);
        refresh();

        // Reset with all agents pending
        tick();
        chk("rst_pop0", 64'(pop[0]), 64'h0);
        chk("rst_push0", 64'(push[0]), 64'h0);
        chk("rst_dpush0", 64'(d_push[0]), 64'h0);
        tick();
        chk("rst_pop1", 64'(pop[0]), 64'h0);
        chk("rst_dpush1", 64'(d_push[0]), 64'h0);
        for (int j = 0; j < 4; j++) q[j].delete();
        refresh();
        reset = 1'b0;
        tick();
        chk("idle_pop", 64'(pop[0]), 64'h0);

        // Unicast agent0 -> agent2
        q[0].push_back(16'h02AB);
        refresh();
        tick();
        chk("uni_pop", 64'(pop[0]), 64'h1);
        chk("uni_nopush", 64'(push[0]), 64'h0);
        tick();
        chk("uni_pop_done", 64'(pop[0]), 64'h0);
        chk("uni_push", 64'(push[0]), 64'h4);
        chk("uni_data", 64'(d_push[0][2]), 64'h02AB);
        tick();
        chk("uni_idle_push", 64'(push[0]), 64'h0);
        chk("uni_hold", 64'(d_push[0][2]), 64'h02AB);

        // Broadcast from agent1
        q[1].push_back(16'hFF55);
        refresh();
        tick();
        chk("bc_pop", 64'(pop[0]), 64'h2);
        tick();
        chk("bc_push", 64'(push[0]), 64'hD);
        chk("bc_d0", 64'(d_push[0][0]), 64'hFF55);
        chk("bc_d2", 64'(d_push[0][2]), 64'hFF55);
        chk("bc_d3", 64'(d_push[0][3]), 64'hFF55);
        tick();

        // Invalid destination from agent3, then agent0 serviced
        q[3].push_back(16'h07CD);
        refresh();
        tick();
        chk("inv_pop", 64'(pop[0]), 64'h8);
        tick();
        chk("inv_nopush", 64'(push[0]), 64'h0);
        q[0].push_back(16'h0312);
        refresh();
        tick();
        chk("inv_idle", 64'(pop[0]), 64'h0);
        tick();
        chk("after_inv_pop", 64'(pop[0]), 64'h1);
        tick();
        chk("after_inv_push", 64'(push[0]), 64'h8);
        chk("after_inv_data", 64'(d_push[0][3]), 64'h0312);
        tick();

        // Reset asserted during the PUSH cycle
        q[2].push_back(16'h0011);
        refresh();
        tick();
        chk("rp_pop", 64'(pop[0]), 64'h4);
        tick();
        chk("rp_push_pre", 64'(push[0]), 64'h1);
        reset = 1'b1;
        tick();
        chk("rp_push_after", 64'(push[0]), 64'h0);
        chk("rp_dpush_clr", 64'(d_push[0]), 64'h0);
        reset = 1'b0;
        q[1].push_back(16'h0200);
        q[3].push_back(16'h0300);
        refresh();
        tick();
        chk("rp_lowest_grant", 64'(pop[0]), 64'h2);
        tick();
        chk("rp_push1", 64'(push[0]), 64'h4);
        tick();
        tick();
        chk("rp_pop3", 64'(pop[0]), 64'h8);
        tick();
        chk("rp_push3", 64'(push[0]), 64'h8);
        tick();

        // Round-robin: two packets per agent, all pending
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                dst = 2'(j + 1);
                q[j].push_back({6'h00, dst, 4'(j), 4'(k)});
            end
        end
        refresh();
        last = 0;
        for (int n = 0; n < 8; n++) begin
            a   = n % 4;
            dst = 2'(a + 1);
            pk  = {6'h00, dst, 4'(a), 4'(n / 4)};
            for (int w = 0; w < 6 && pop[0] === 4'h0; w++) tick();
            chk("rr_pop", 64'(pop[0]), 64'(4'b0001 << a));
            if (n > 0) chk("rr_gap", 64'(cyc - last), 64'd3);
            last = cyc;
            tick();
            chk("rr_push", 64'(push[0]), 64'(4'b0001 << dst));
            chk("rr_data", 64'(d_push[0][dst]), 64'(pk));
        end
        tick();
        chk("rr_drained", 64'(pndng[0]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_generator_arbiter.md
Name: bus_generator_arbiter

Overview:
- Shared-bus generator/arbiter between `drvrs` agents on each of `bits` independent buses.
- Each agent owns an external first-word-fall-through FIFO that reports pending packets and presents its head word.
- The block round-robin grants one pending agent per bus and pops its packet.
- It routes the packet by its destination byte to one agent's input, or to every other agent for broadcast.

Parameters:
- bits, 1, number of independent buses (one arbiter lane each)
- drvrs, 4, number of agents per bus
- pckg_sz, 16, packet width in bits; must be >= 9
- broadcast, 8'hFF, destination-ID value meaning "deliver to all agents except the source"

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- pndng  input  [bits-1:0][drvrs-1:0]  agent FIFO not empty
- D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  agent FIFO head word, valid while pndng=1
- pop  output  [bits-1:0][drvrs-1:0]  one-cycle dequeue strobe to an agent FIFO
- push  output  [bits-1:0][drvrs-1:0]  one-cycle write strobe into an agent's receive side
- D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  data accompanying push

Behaviour:
- Packet format:
  - [pckg_sz-1 : pckg_sz-8] = destination ID.
  - Remaining bits = payload, carried unmodified.
  - The whole word is forwarded unchanged.
- Reset (reset=1 at a rising edge):
  - All pop, push and D_push are 0 from the next cycle.
  - FSM goes to IDLE; round-robin pointer goes to 0; latched packet is cleared.
  - Reset mid-transfer aborts the transfer; the packet is not delivered.
- Per-lane FSM: IDLE -> POP -> PUSH -> IDLE.
  - IDLE: if any pndng[b] bit is set, latch grant = first pending index at or after the pointer, wrapping modulo drvrs; go to POP. Otherwise stay in IDLE.
  - POP: pop[b][grant] = pndng[b][grant], combinational from the registered state. Capture D_pop[b][grant] into the packet register at the end of the cycle. Advance the pointer to grant+1 mod drvrs. Go to PUSH.
    - If pndng[b][grant] is low in POP: no pop, no capture, return to IDLE, pointer unchanged.
  - PUSH: decode the destination and drive push for exactly one cycle, with D_push = captured packet on every asserted port. Go to IDLE.
- Destination decode in PUSH:
  - dest == broadcast: push all j != grant.
  - dest < drvrs: push[b][dest]; dest == grant is allowed and delivered back to the source.
  - Otherwise: packet dropped, no push.
- Timing: pop asserts 1 cycle after pndng is seen in IDLE; push asserts 1 cycle after pop. Minimum 3 cycles per packet per lane.
- Outputs at most one pop per lane per cycle. Non-selected pop/push bits are 0.
- D_push for non-pushed ports holds its last value. Only push qualifies D_push.
- Lanes are fully independent and may transfer simultaneously.
- Fairness: with all agents pending continuously, grants cycle 0,1,...,drvrs-1,0,... and no agent waits more than drvrs transfers.

Decomposition:
- Package bus_pkg:
  - ID_W=8
  - the state enum {IDLE, POP, PUSH}
  - a function extracting the destination ID from a packet
  - a round-robin next-grant function (pointer, pending vector)
- One sub-module, bus_lane_arbiter: one bus's FSM, pointer and packet register.
- Top generates `bits` instances and slices the packed arrays.

Test Plan:
- Reset with pndng=4'b1111 held: pop, push and D_push are all 0 during reset and the first cycle after.
- Unicast: agent0 pending with D_pop=16'h02AB.
  - pop[0][0]=1 for one cycle.
  - Next cycle push[0]=4'b0100 with D_push[0][2]=16'h02AB.
  - Then idle.
- Broadcast: agent1 pending with 16'hFF55. One pop of agent1, then push[0]=4'b1101 with D_push=16'hFF55 on ports 0, 2 and 3.
- Round-robin: all four agents each hold 2 packets. The pop sequence is agents 0,1,2,3,0,1,2,3, spaced 3 cycles apart, and all 8 packets are delivered.
- Invalid destination: agent3 sends 16'h07CD. pop[0][3] pulses, no push follows, and the next packet from agent0 is serviced normally.
- Reset asserted in the PUSH cycle: no push is seen after the reset edge, the pointer returns to 0, and the next grant goes to the lowest pending agent.
